// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Read-side controller for a FIFO with a registered read port
//               (rdata valid the cycle after rd_en). Converts FIFO reads
//               into a valid/ready output stream through a 2-entry skid
//               buffer. It also counts delivered words and keeps a sticky
//               underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             empty,
  input  logic             underflow,
  input  logic [DW-1:0]    rdata,
  output logic             rd_en,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] rd_count,
  output logic             underflow_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] head;       // oldest buffered word, shown on m_data
  logic [DW-1:0] tail;       // second buffered word (valid when occ == 2)
  logic [1:0]    occ;        // number of buffered words, 0..2
  logic          inflight;   // a FIFO read was issued last cycle
  logic          pop;        // output transfer this cycle
  logic [2:0]    committed;  // slots still spoken for after this cycle's pop

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = head;

  // A word being popped is always buffered, so this never goes negative.
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // New read only while running and only if its word will find a free slot.
  assign rd_en = (state == ST_RUN) && enable && !empty && (committed <= 3'd1);

  // Control FSM; busy is registered alongside the state it mirrors.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (enable) begin
            state <= ST_RUN;
          end else if ((occ == 2'd0) && !inflight) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Skid buffer: capture returning read data at the tail, pop from the head.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      case ({inflight, pop})
        2'b10: begin
          // Capture only.
          if (occ == 2'd0) begin
            head <= rdata;
            occ  <= 2'd1;
          end else if (occ == 2'd1) begin
            tail <= rdata;
            occ  <= 2'd2;
          end
        end
        2'b01: begin
          // Pop only: the second word (if any) moves to the head.
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Capture and pop together: occupancy unchanged, order kept.
          if (occ == 2'd1) begin
            head <= rdata;
          end else begin
            head <= tail;
            tail <= rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + CNT_ONE;
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_err <= 1'b0;
    end else if (underflow) begin
      underflow_err <= 1'b1;
    end
  end

  // A capture into a full buffer with nothing leaving would overwrite live data.
  a_no_overfill: assert property (@(posedge rd_clk) disable iff (!rst_n)
    !(inflight && (occ == 2'd2) && !pop));

  // The FIFO must never be strobed while it reports empty.
  a_no_read_empty: assert property (@(posedge rd_clk) disable iff (!rst_n)
    !(rd_en && empty));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_ctrl
// Description : Self-checking bench for fifo_rd_ctrl. The bench plays the
//               external FIFO (a queue of words) and scores every output
//               transfer against the words it handed out, in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

  localparam int DW    = 8;
  localparam int CNT_W = 16;

  logic             rd_clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             empty;
  logic             underflow;
  logic [DW-1:0]    rdata;
  logic             rd_en;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic             m_ready;
  logic [CNT_W-1:0] rd_count;
  logic             underflow_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
    .rd_clk        (rd_clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .empty         (empty),
    .underflow     (underflow),
    .rdata         (rdata),
    .rd_en         (rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .rd_count      (rd_count),
    .underflow_err (underflow_err),
    .busy          (busy)
  );

  // Reference model state
  logic [DW-1:0]    fifo_q[$];   // words still inside the external FIFO
  logic [DW-1:0]    exp_q[$];    // words read from the FIFO, not yet delivered
  logic [CNT_W-1:0] model_count;
  logic             model_err;
  logic             prev_rd;     // a read was strobed in the previous cycle
  logic             hold_valid;  // last cycle had valid data stalled
  logic [DW-1:0]    hold_data;
  int               cyc;

  // Observations from the most recent cycle
  logic             last_rd_en, last_xfer, last_busy, last_valid, last_err;
  logic [DW-1:0]    last_data;
  logic [CNT_W-1:0] last_count;

  function automatic void push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endfunction

  function automatic void clear_model();
    fifo_q.delete();
    exp_q.delete();
    model_count = '0;
    model_err   = 1'b0;
    prev_rd     = 1'b0;
    hold_valid  = 1'b0;
    empty       = 1'b1;
  endfunction

  // One clock cycle: sample and score at the falling edge, then act as the
  // FIFO (return read data) just after the next rising edge.
  task automatic cycle();
    int            outstanding;
    int            pop_i;
    logic          exp_valid;
    logic          got_word;
    logic [DW-1:0] word;
    logic [DW-1:0] want;
    @(negedge rd_clk);
    cyc++;
    outstanding = exp_q.size();
    pop_i       = (m_valid === 1'b1 && m_ready === 1'b1) ? 1 : 0;
    // A word is visible once its read is at least two cycles old.
    exp_valid   = ((outstanding - (prev_rd ? 1 : 0)) > 0);
    checks++;
    if (m_valid !== exp_valid) begin
      failures++;
      $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, exp_valid);
    end
    if (hold_valid) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== hold_data) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got=%b/%0h exp=1/%0h", cyc, m_valid, m_data, hold_data);
      end
    end
    if (rd_en === 1'b1) begin
      checks++;
      if (empty) begin
        failures++;
        $display("FAIL rd_en_empty cyc=%0d got=1 exp=0", cyc);
      end
      checks++;
      if (outstanding - pop_i > 1) begin
        failures++;
        $display("FAIL rd_en_room cyc=%0d got=1 exp=0 (outstanding=%0d)", cyc, outstanding);
      end
    end
    checks++;
    if (rd_count !== model_count) begin
      failures++;
      $display("FAIL rd_count cyc=%0d got=%0h exp=%0h", cyc, rd_count, model_count);
    end
    checks++;
    if (underflow_err !== model_err) begin
      failures++;
      $display("FAIL underflow_err cyc=%0d got=%b exp=%b", cyc, underflow_err, model_err);
    end
    if (pop_i == 1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL xfer_data cyc=%0d got=%0h exp=none", cyc, m_data);
      end else begin
        want = exp_q.pop_front();
        if (m_data !== want) begin
          failures++;
          $display("FAIL xfer_data cyc=%0d got=%0h exp=%0h", cyc, m_data, want);
        end
      end
      model_count = model_count + 1'b1;
    end
    if (underflow) model_err = 1'b1;
    hold_valid = (m_valid === 1'b1) && !m_ready;
    hold_data  = m_data;
    last_rd_en = (rd_en === 1'b1);
    last_xfer  = (pop_i == 1);
    last_busy  = busy;
    last_valid = m_valid;
    last_err   = underflow_err;
    last_data  = m_data;
    last_count = rd_count;
    got_word   = 1'b0;
    word       = '0;
    if (rd_en === 1'b1 && fifo_q.size() > 0) begin
      word = fifo_q.pop_front();
      exp_q.push_back(word);
      got_word = 1'b1;
    end
    prev_rd = (rd_en === 1'b1);
    @(posedge rd_clk);
    #1;
    rdata = got_word ? word : DW'($urandom);
    empty = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    m_ready   = 1'b0;
    underflow = 1'b0;
    repeat (2) @(posedge rd_clk);
    #3 rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; empty = 1'b1; underflow = 1'b0;
    rdata = '0; m_ready = 1'b0;
    clear_model();
    cyc = 0;
    #1;
    checks++; if (rd_en !== 1'b0)         begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    checks++; if (m_valid !== 1'b0)       begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== '0)          begin failures++; $display("FAIL reset_m_data got=%0h exp=0", m_data); end
    checks++; if (rd_count !== '0)        begin failures++; $display("FAIL reset_rd_count got=%0h exp=0", rd_count); end
    checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL reset_uf_err got=%b exp=0", underflow_err); end
    checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (2) @(posedge rd_clk);
    #3 rst_n = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_basic();
    logic [DW-1:0] pat [3];
    logic [DW-1:0] xd [3];
    int            xc [3];
    int            first_rd;
    int            n;
    pat = '{8'h11, 8'h22, 8'h33};
    first_rd = -1;
    n = 0;
    enable  = 1'b1;
    m_ready = 1'b1;
    repeat (3) cycle();
    checks++; if (last_rd_en !== 1'b0) begin failures++; $display("FAIL basic_no_read_empty got=%b exp=0", last_rd_en); end
    checks++; if (last_busy !== 1'b1)  begin failures++; $display("FAIL basic_busy got=%b exp=1", last_busy); end
    for (int i = 0; i < 3; i++) push_word(pat[i]);
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_rd_en && first_rd < 0) first_rd = cyc;
      if (last_xfer) begin
        if (n < 3) begin
          xc[n] = cyc;
          xd[n] = last_data;
        end
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      failures++; $display("FAIL basic_count got=%0d exp=3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (xd[i] !== pat[i]) begin failures++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, xd[i], pat[i]); end
        checks++;
        if (xc[i] != first_rd + 2 + i) begin failures++; $display("FAIL basic_cycle[%0d] got=%0d exp=%0d", i, xc[i], first_rd + 2 + i); end
      end
    end
    checks++; if (last_count !== 16'd3) begin failures++; $display("FAIL basic_rd_count got=%0d exp=3", last_count); end
    enable = 1'b0;
    repeat (4) cycle();
    checks++; if (last_busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", last_busy); end
  endtask

  task automatic test_back_to_back();
    int n, first_x, last_x;
    n = 0; first_x = -1; last_x = -1;
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_word(DW'($urandom));
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (last_xfer) begin
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        n++;
      end
    end
    checks++; if (n != 20) begin failures++; $display("FAIL b2b_count got=%0d exp=20", n); end
    checks++; if (last_x - first_x != 19) begin failures++; $display("FAIL b2b_span got=%0d exp=19", last_x - first_x); end
    enable = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] stall_data;
    int            k;
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) push_word(DW'($urandom));
    repeat (4) cycle();
    m_ready = 1'b0;
    stall_data = '0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) stall_data = last_data;
      if (i >= 2) begin
        checks++;
        if (last_rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_stop[%0d] got=1 exp=0", i); end
      end
    end
    checks++; if (exp_q.size() != 2) begin failures++; $display("FAIL bp_held_words got=%0d exp=2", exp_q.size()); end
    checks++; if (last_valid !== 1'b1 || last_data !== stall_data) begin failures++; $display("FAIL bp_data_hold got=%0h exp=%0h", last_data, stall_data); end
    m_ready = 1'b1;
    k = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0) && k < 40) begin
      cycle();
      k++;
    end
    checks++; if (fifo_q.size() != 0 || exp_q.size() != 0) begin failures++; $display("FAIL bp_release got=%0d left exp=0", fifo_q.size() + exp_q.size()); end
    enable = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_drain();
    int n;
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    repeat (5) cycle();
    checks++; if (exp_q.size() != 2 || prev_rd) begin failures++; $display("FAIL drain_setup got=%0d/%b exp=2/0", exp_q.size(), prev_rd); end
    enable  = 1'b0;
    m_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_xfer) n++;
      checks++;
      if (last_rd_en !== 1'b0) begin failures++; $display("FAIL drain_rd_en[%0d] got=1 exp=0", i); end
      checks++;
      if (last_busy !== (i < 3)) begin failures++; $display("FAIL drain_busy[%0d] got=%b exp=%b", i, last_busy, (i < 3)); end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL drain_xfers got=%0d exp=2", n); end
    checks++; if (fifo_q.size() != 2) begin failures++; $display("FAIL drain_fifo_left got=%0d exp=2", fifo_q.size()); end
    fifo_q.delete();
    empty = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(7) != 0);
      m_ready = ($urandom_range(2) != 0);
      if ($urandom_range(1) == 1 && fifo_q.size() < 4) push_word(DW'($urandom));
      cycle();
    end
    enable  = 1'b0;
    m_ready = 1'b1;
    k = 0;
    while ((exp_q.size() > 0 || last_busy) && k < 20) begin
      cycle();
      k++;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_flush got=%0d exp=0", exp_q.size()); end
    checks++; if (last_busy !== 1'b0) begin failures++; $display("FAIL rand_idle got=%b exp=0", last_busy); end
    fifo_q.delete();
    empty = 1'b1;
  endtask

  task automatic test_wrap();
    int k;
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    k = 0;
    while (model_count != 16'hFFFF && k < 70000) begin
      if (fifo_q.size() < 3) push_word(DW'($urandom));
      cycle();
      k++;
    end
    checks++; if (model_count != 16'hFFFF) begin failures++; $display("FAIL wrap_timeout got=%0h exp=ffff", model_count); end
    if (fifo_q.size() < 3) push_word(DW'($urandom));
    cycle();
    checks++; if (last_count !== 16'hFFFF || !last_xfer) begin failures++; $display("FAIL wrap_preload got=%0h/%b exp=ffff/1", last_count, last_xfer); end
    cycle();
    checks++; if (last_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%0h exp=0", last_count); end
    enable = 1'b0;
    fifo_q.delete();
    empty = 1'b1;
    repeat (6) cycle();
  endtask

  task automatic test_underflow_reset();
    int  n;
    logic seen;
    underflow = 1'b1;
    cycle();
    underflow = 1'b0;
    checks++; if (last_err !== 1'b0) begin failures++; $display("FAIL uf_same_cycle got=%b exp=0", last_err); end
    cycle();
    checks++; if (last_err !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", last_err); end
    repeat (3) cycle();
    checks++; if (last_err !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", last_err); end
    enable  = 1'b1;
    m_ready = 1'b0;
    push_word(8'hA5);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = last_valid;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_setup got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_en !== 1'b0)         begin failures++; $display("FAIL arst_rd_en got=%b exp=0", rd_en); end
    checks++; if (m_valid !== 1'b0)       begin failures++; $display("FAIL arst_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== '0)          begin failures++; $display("FAIL arst_m_data got=%0h exp=0", m_data); end
    checks++; if (rd_count !== '0)        begin failures++; $display("FAIL arst_rd_count got=%0h exp=0", rd_count); end
    checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL arst_uf_err got=%b exp=0", underflow_err); end
    checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    enable  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge rd_clk);
    #3 rst_n = 1'b1;
    clear_model();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_xfer) n++;
    end
    checks++; if (n != 0) begin failures++; $display("FAIL rst_discard got=%0d exp=0", n); end
    checks++; if (last_count !== '0) begin failures++; $display("FAIL rst_count got=%0h exp=0", last_count); end
    // Resume from IDLE after reset: a fresh word must come through.
    enable = 1'b1;
    push_word(8'h3C);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_xfer) n++;
    end
    checks++; if (n != 1) begin failures++; $display("FAIL rst_resume got=%0d exp=1", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_drain();
    test_random();
    test_wrap();
    test_underflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data word width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the delivered-word counter.
REQ-003 SHALL have port rd_clk  input  1  read-domain clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  permits new FIFO reads when high.
REQ-006 SHALL have port empty  input  1  FIFO empty flag, already in rd_clk domain.
REQ-007 SHALL have port underflow  input  1  FIFO underflow flag.
REQ-008 SHALL have port rdata  input  DW  FIFO read data, valid the cycle after rd_en.
REQ-009 SHALL have port rd_en  output  1  FIFO read strobe.
REQ-010 SHALL have port m_valid  output  1  output stream data valid.
REQ-011 SHALL have port m_data  output  DW  output stream data.
REQ-012 SHALL have port m_ready  input  1  downstream accepts data.
REQ-013 SHALL have port rd_count  output  CNT_W  words delivered on the output stream.
REQ-014 SHALL have port underflow_err  output  1  sticky underflow indication.
REQ-015 SHALL have port busy  output  1  high in RUN or DRAIN state.

Function
REQ-016 SHALL use a 2-entry skid buffer (occ 0..2) and a 1-bit in-flight flag (inflight = rd_en of the previous cycle).
REQ-017 SHALL implement states IDLE, RUN, DRAIN.
REQ-018 SHALL transition IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when occ=0 and inflight=0; DRAIN->RUN when enable=1.
REQ-019 SHALL drive rd_en combinationally = (state==RUN) && enable && !empty && (occ + inflight - pop <= 1), where pop = m_valid && m_ready.
REQ-020 SHALL never assert rd_en while empty=1.
REQ-021 SHALL capture rdata into the buffer tail at the rising edge ending the cycle after rd_en (inflight=1).
REQ-022 SHALL present the buffer head on m_data with m_valid=1 whenever occ>0: a word read in cycle N, with occ=0, is visible in cycle N+2.
REQ-023 SHALL perform a transfer only when m_valid && m_ready; m_data and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 SHALL support simultaneous capture and pop in one cycle with occ unchanged, preserving FIFO order.
REQ-025 SHALL sustain one word per cycle when empty=0, enable=1 and m_ready held high.
REQ-026 SHALL never capture while occ=2 and no pop; a capture in that condition is a design error flagged by assertion.
REQ-027 SHALL increment rd_count by 1 per transfer and wrap modulo 2^CNT_W (all-ones -> 0).
REQ-028 SHALL set underflow_err the cycle after underflow=1 and hold it until reset.
REQ-029 SHALL still deliver buffered and in-flight words in DRAIN without issuing new rd_en.
REQ-030 SHALL drive busy=1 exactly when the state is RUN or DRAIN.

Reset
REQ-031 SHALL, while rst_n=0, immediately force: state IDLE, occ=0, inflight=0, rd_en=0, m_valid=0, m_data=0, rd_count=0, underflow_err=0, busy=0.
REQ-032 SHALL discard buffered and in-flight words on reset mid-operation, with no transfer reported after reset.
REQ-033 SHALL resume from IDLE on the first rising edge after rst_n deasserts.

Verification
REQ-034 Basic: enable=1, empty falls with rdata sequence 0x11,0x22,0x33, m_ready=1 -> m_data 0x11,0x22,0x33 in order on consecutive cycles, first at rd_en cycle+2, rd_count=3.
REQ-035 Backpressure: m_ready=0 for 5 cycles during stream -> rd_en stops after occ+inflight=2, m_data held constant, no loss; on release, order intact.
REQ-036 Drain: enable falls with occ=2 -> state DRAIN, no rd_en, 2 transfers, then IDLE with busy=0.
REQ-037 Wrap: preload rd_count=0xFFFF via 65535 transfers, one more transfer -> rd_count=0x0000.
REQ-038 Underflow/reset: pulse underflow 1 cycle -> underflow_err=1 sticky; assert rst_n=0 mid-stream with occ=1 -> all outputs 0 asynchronously, buffered word never appears.
